pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards and handles taken branches and j/jal/jr redirects.
- Runs the req/ack handshake with the multi-cycle data memory, freezing the pipe until ack.
- Drives every pipeline-register enable and flush, and keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 57 +++++
 rtl/pipeline_hazard_ctrl_if.sv | 44 ++++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared MIPS control codes, hazard FSM states and pipe-control vectors
// Purpose: MemRead/MemWrite and Jump encodings shared by Control, the datapath and
//          the hazard sequencer, plus the hazard FSM encoding and canned pipe-control words.
// Ports:   none (package)
package mips_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_WORD = 2'b01,
        MEM_BYTE = 2'b10,
        MEM_HALF = 2'b11
    } mem_code_t;

    typedef enum logic [1:0] {
        JMP_NONE = 2'b00,
        JMP_J    = 2'b01,
        JMP_JAL  = 2'b10,
        JMP_JR   = 2'b11
    } jump_code_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } hz_state_t;

    // Every pipeline-register control the sequencer owns, in one word.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic idex_write;
        logic exmem_write;
        logic memwb_bubble;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_DEFAULT = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                          idex_bubble: 1'b0, idex_write: 1'b1, exmem_write: 1'b1,
                                          memwb_bubble: 1'b0};

    // Freeze holds every stage and drains a NOP into WB so the stalled MEM
    // instruction is not written back twice.
    localparam pipe_ctl_t CTL_FREEZE  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                          idex_bubble: 1'b0, idex_write: 1'b0, exmem_write: 1'b0,
                                          memwb_bubble: 1'b1};

    // Applied while rst_n is low: every register downstream of PC loads a NOP.
    localparam pipe_ctl_t CTL_RESET   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                          idex_bubble: 1'b1, idex_write: 1'b1, exmem_write: 1'b1,
                                          memwb_bubble: 1'b1};

    function automatic logic mem_active(input logic [1:0] code);
        return code != MEM_NONE;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard sequencer signal bundle
// Purpose: groups the pipeline status inputs, data-memory handshake and pipe controls.
// Ports:   slave modport  = hazard controller view (status/ack in, controls/req out)
//          master modport = datapath/memory view (status/ack out, controls/req in)
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [1:0]       id_jump;
    logic [1:0]       ex_mem_read;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic [1:0]       mem_mem_read;
    logic [1:0]       mem_mem_write;
    logic             dmem_ack;
    logic             stat_clr;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             idex_write;
    logic             exmem_write;
    logic             memwb_bubble;
    logic             dmem_req;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt, ex_branch_taken,
               mem_mem_read, mem_mem_write, dmem_ack, stat_clr,
        output pc_write, ifid_write, ifid_flush, idex_bubble, idex_write, exmem_write,
               memwb_bubble, dmem_req, mem_err, stall_cnt
    );

    modport master (
        output id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt, ex_branch_taken,
               mem_mem_read, mem_mem_write, dmem_ack, stat_clr,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_write, exmem_write,
               memwb_bubble, dmem_req, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// rtl/pipeline_hazard_ctrl_load_use_detect.sv - combinational load-use hazard detector
// Purpose: flags an ID instruction that sources the register a load in EX is about to write.
// Ports:   i_ex_mem_read/i_ex_rt  load in EX and its destination
//          i_id_rs/i_id_rt/i_id_uses_rt  ID source operands
//          o_load_use  hazard present this cycle
module load_use_detect
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] i_ex_mem_read,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    output logic       o_load_use
);
    logic w_rs_hit;
    logic w_rt_hit;

    // $zero is never a real dependency, whatever the load targets.
    assign w_rs_hit   = (i_ex_rt == i_id_rs);
    assign w_rt_hit   = i_id_uses_rt && (i_ex_rt == i_id_rt);
    assign o_load_use = mem_active(i_ex_mem_read) && (i_ex_rt != 5'd0) && (w_rs_hit || w_rt_hit);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage MIPS pipeline
// Purpose: load-use stalls, branch/jump flushes, data-memory req/ack freeze with timeout,
//          and a saturating stall-cycle counter.
// Ports:   clk    rising-edge clock
//          rst_n  synchronous active-low reset
//          hz     pipeline_hazard_ctrl_if.slave (status in, pipe controls / dmem_req out)
module pipeline_hazard_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz
);
    localparam int TO_W = $clog2(MEM_TIMEOUT) + 1;

    hz_state_t        r_state;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_dmem_req;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_load_use;
    logic             w_mem_op;
    logic             w_freeze;
    pipe_ctl_t        w_ctl;

    load_use_detect u_load_use_detect (
        .i_ex_mem_read (hz.ex_mem_read),
        .i_ex_rt       (hz.ex_rt),
        .i_id_rs       (hz.id_rs),
        .i_id_rt       (hz.id_rt),
        .i_id_uses_rt  (hz.id_uses_rt),
        .o_load_use    (w_load_use)
    );

    assign w_mem_op = mem_active(hz.mem_mem_read) || mem_active(hz.mem_mem_write);

    // In MEM_WAIT the MEM instruction is already being served, so mem_op is
    // ignored there; a back-to-back op is picked up in RUN the cycle after ack.
    always_comb begin
        w_freeze = 1'b1;
        case (r_state)
            ST_RUN:      w_freeze = w_mem_op;
            ST_MEM_WAIT: w_freeze = !hz.dmem_ack;
            default:     w_freeze = 1'b1;
        endcase
    end

    // Priority: error/memory freeze > taken branch > load-use > jump.
    // A jr stalled by load-use on rs gets its flush on the following cycle,
    // once the load has moved to MEM.
    always_comb begin
        w_ctl = CTL_DEFAULT;
        if (!rst_n) begin
            w_ctl = CTL_RESET;
        end else if (w_freeze) begin
            w_ctl = CTL_FREEZE;
        end else if (hz.ex_branch_taken) begin
            w_ctl.ifid_flush  = 1'b1;
            w_ctl.idex_bubble = 1'b1;
        end else if (w_load_use) begin
            w_ctl.pc_write    = 1'b0;
            w_ctl.ifid_write  = 1'b0;
            w_ctl.idex_bubble = 1'b1;
        end else if (hz.id_jump != JMP_NONE) begin
            w_ctl.ifid_flush  = 1'b1;
        end
    end

    // Memory handshake FSM; dmem_req and mem_err are registered with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_to_cnt   <= '0;
            r_dmem_req <= 1'b0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_op) begin
                        r_state    <= ST_MEM_WAIT;
                        r_to_cnt   <= '0;
                        r_dmem_req <= 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (hz.dmem_ack) begin
                        r_state    <= ST_RUN;
                        r_dmem_req <= 1'b0;
                    end else if (r_to_cnt == TO_W'(MEM_TIMEOUT - 1)) begin
                        r_state    <= ST_ERROR;
                        r_dmem_req <= 1'b0;
                        r_mem_err  <= 1'b1;
                    end else begin
                        r_to_cnt   <= r_to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    // ERROR and the unused encoding both lock up until reset.
                    r_state    <= ST_ERROR;
                    r_dmem_req <= 1'b0;
                    r_mem_err  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (hz.stat_clr) begin
            r_stall_cnt <= '0;
        end else if (!w_ctl.pc_write && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign hz.pc_write     = w_ctl.pc_write;
    assign hz.ifid_write   = w_ctl.ifid_write;
    assign hz.ifid_flush   = w_ctl.ifid_flush;
    assign hz.idex_bubble  = w_ctl.idex_bubble;
    assign hz.idex_write   = w_ctl.idex_write;
    assign hz.exmem_write  = w_ctl.exmem_write;
    assign hz.memwb_bubble = w_ctl.memwb_bubble;
    assign hz.dmem_req     = r_dmem_req && rst_n;
    assign hz.mem_err      = r_mem_err;
    assign hz.stall_cnt    = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    // {pc_write, ifid_write, ifid_flush, idex_bubble, idex_write, exmem_write, memwb_bubble, dmem_req}
    localparam logic [7:0] C_RESET  = 8'b0011_1110;
    localparam logic [7:0] C_IDLE   = 8'b1100_1100;
    localparam logic [7:0] C_LU     = 8'b0001_1100;
    localparam logic [7:0] C_BR     = 8'b1111_1100;
    localparam logic [7:0] C_JMP    = 8'b1110_1100;
    localparam logic [7:0] C_FRZ    = 8'b0000_0010;
    localparam logic [7:0] C_FRZREQ = 8'b0000_0011;
    localparam logic [7:0] C_ACK    = 8'b1100_1101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: busy = a memory op is outstanding, waited = no-ack cycles so far.
    bit m_busy   = 1'b0;
    int m_waited = 0;
    bit m_err    = 1'b0;
    int m_cnt    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic model_mem_op();
        return (hz.mem_mem_read != 2'b00) || (hz.mem_mem_write != 2'b00);
    endfunction

    function automatic logic [7:0] exp_ctl();
        logic lu;
        logic frz;
        logic [6:0] c;
        if (!rst_n) return C_RESET;
        lu  = (hz.ex_mem_read != 2'b00) && (hz.ex_rt != 5'd0) &&
              ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && hz.ex_rt == hz.id_rt));
        frz = m_err || (m_busy ? !hz.dmem_ack : model_mem_op());
        c   = C_IDLE[7:1];
        if (frz)                     c = C_FRZ[7:1];
        else if (hz.ex_branch_taken) c = C_BR[7:1];
        else if (lu)                 c = C_LU[7:1];
        else if (hz.id_jump != 2'b00) c = C_JMP[7:1];
        return {c, m_busy};
    endfunction

    function automatic logic [7:0] dut_ctl();
        return {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble,
                hz.idex_write, hz.exmem_write, hz.memwb_bubble, hz.dmem_req};
    endfunction

    always @(posedge clk) begin : model_update
        logic [7:0] e;
        e = exp_ctl();
        if (!rst_n) begin
            m_busy = 1'b0; m_waited = 0; m_err = 1'b0; m_cnt = 0;
        end else begin
            if (hz.stat_clr)            m_cnt = 0;
            else if (!e[7] && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (!m_err) begin
                if (m_busy) begin
                    if (hz.dmem_ack) m_busy = 1'b0;
                    else begin
                        m_waited = m_waited + 1;
                        if (m_waited == TO) begin m_busy = 1'b0; m_err = 1'b1; end
                    end
                end else if (model_mem_op()) begin
                    m_busy = 1'b1; m_waited = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model_ctl", 32'(dut_ctl()), 32'(exp_ctl()));
        check("model_mem_err", 32'(hz.mem_err), 32'(m_err));
        check("model_stall_cnt", 32'(hz.stall_cnt), 32'(m_cnt));
    end

    task automatic idle();
        hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b0; hz.id_jump = 2'b00;
        hz.ex_mem_read = 2'b00; hz.ex_rt = 5'd0; hz.ex_branch_taken = 1'b0;
        hz.mem_mem_read = 2'b00; hz.mem_mem_write = 2'b00; hz.dmem_ack = 1'b0;
        hz.stat_clr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [7:0] exp);
        @(negedge clk);
        check(name, 32'(dut_ctl()), 32'(exp));
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        lit("reset_ctl", C_RESET);
        step();
        rst_n = 1'b1;
        lit("run_idle", C_IDLE);
        check("reset_cnt", 32'(hz.stall_cnt), 32'd0);
        check("reset_err", 32'(hz.mem_err), 32'd0);

        // lw $t0 in EX, add in ID reads $t0 via rs
        step(); hz.ex_mem_read = 2'b01; hz.ex_rt = 5'd8; hz.id_rs = 5'd8;
        lit("lu_rs_stall", C_LU);
        step(); idle();
        lit("lu_one_cycle", C_IDLE);
        check("lu_cnt", 32'(hz.stall_cnt), 32'd1);

        // no hazard on $zero or on an rt that is not read
        step(); hz.ex_mem_read = 2'b01; hz.ex_rt = 5'd0; hz.id_rs = 5'd0;
        lit("lu_zero", C_IDLE);
        step(); hz.ex_rt = 5'd8; hz.id_rs = 5'd3; hz.id_rt = 5'd8; hz.id_uses_rt = 1'b0;
        lit("lu_rt_unused", C_IDLE);
        step(); hz.id_uses_rt = 1'b1;
        lit("lu_rt_used", C_LU);

        // taken branch beats load-use
        step(); idle(); hz.ex_mem_read = 2'b01; hz.ex_rt = 5'd8; hz.id_rs = 5'd8;
        hz.ex_branch_taken = 1'b1;
        lit("branch_over_lu", C_BR);

        // jr on a loaded rs: stall first, flush next cycle
        step(); idle(); hz.ex_mem_read = 2'b01; hz.ex_rt = 5'd8; hz.id_rs = 5'd8;
        hz.id_jump = 2'b11;
        lit("jr_stall", C_LU);
        step(); hz.ex_mem_read = 2'b00; hz.ex_rt = 5'd0;
        lit("jr_flush", C_JMP);
        check("cnt_after_jr", 32'(hz.stall_cnt), 32'd3);

        // sw in MEM, ack on the third request cycle
        step(); idle(); hz.mem_mem_write = 2'b01;
        lit("sw_detect", C_FRZ);
        for (int i = 0; i < 2; i++) begin
            step();
            lit("sw_wait", C_FRZREQ);
        end
        step(); hz.dmem_ack = 1'b1;
        lit("sw_ack", C_ACK);
        // new op presented in the ack cycle is served afterwards
        step(); hz.dmem_ack = 1'b0; hz.mem_mem_read = 2'b10; hz.mem_mem_write = 2'b00;
        lit("b2b_detect", C_FRZ);
        step(); hz.dmem_ack = 1'b1;
        lit("b2b_ack", C_ACK);
        step(); idle();
        lit("b2b_done", C_IDLE);
        check("cnt_after_mem", 32'(hz.stall_cnt), 32'd7);

        // lw in MEM, memory never answers
        step(); hz.mem_mem_read = 2'b01;
        lit("to_detect", C_FRZ);
        for (int i = 0; i < TO; i++) begin
            step();
            lit("to_wait", C_FRZREQ);
        end
        step();
        lit("to_error", C_FRZ);
        check("to_mem_err", 32'(hz.mem_err), 32'd1);
        repeat (6) step();
        hz.mem_mem_read = 2'b00;
        lit("err_sticky", C_FRZ);
        check("cnt_saturated", 32'(hz.stall_cnt), 32'(CNT_MAX));
        hz.stat_clr = 1'b1;
        step(); hz.stat_clr = 1'b0;
        lit("err_after_clr", C_FRZ);
        check("cnt_cleared", 32'(hz.stall_cnt), 32'd0);
        step();
        lit("err_counting", C_FRZ);
        check("cnt_restart", 32'(hz.stall_cnt), 32'd1);
        check("err_still", 32'(hz.mem_err), 32'd1);

        rst_n = 1'b0;
        lit("rst_again", C_RESET);
        step(); rst_n = 1'b1;
        lit("rst_run", C_IDLE);
        check("rst_err", 32'(hz.mem_err), 32'd0);
        check("rst_cnt", 32'(hz.stall_cnt), 32'd0);

        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
